// File: rtl/sparse_fetcher_if.sv
// Consumer-side bus of the sparse operand fetcher.
//   val_read : pop request from the consumer
//   out      : current head word (0 while empty)
//   empty    : no valid word available
// master = consumer side, slave = fetcher side.
interface sparse_fetcher_if #(
    parameter int unsigned WIDTH = 8
);
    logic             val_read;
    logic [WIDTH-1:0] out;
    logic             empty;

    modport master (
        output val_read,
        input  out,
        input  empty
    );

    modport slave (
        input  val_read,
        output out,
        output empty
    );
endinterface

// File: rtl/sparse_fetcher.sv
// Sparse-matrix operand stream source. A fixed ROM (rom[i] = i+1) is streamed
// through a small first-word-fall-through prefetch buffer to the consumer.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears all state
//   bus  : sparse_fetcher_if.slave (val_read in, out/empty out)
// BUF_DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sparse_fetcher #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    sparse_fetcher_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CRD_W  = CNT_W + 1;

    // ROM read side
    logic [ADDR_W-1:0] rd_addr;
    logic              in_flight;
    logic [WIDTH-1:0]  rom_q;

    // Prefetch buffer
    logic [WIDTH-1:0]  buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Per-cycle control
    logic              is_empty;
    logic              push;
    logic              pop;
    logic              issue;
    logic [CRD_W-1:0]  credit_used;

    // Fixed stream contents: word i holds i+1, truncated to WIDTH.
    function automatic logic [WIDTH-1:0] rom_word(input logic [ADDR_W-1:0] addr);
        return WIDTH'(32'(addr) + 32'd1);
    endfunction

    assign is_empty = (count == '0);

    // The registered ROM word always lands in the buffer the edge after issue.
    assign push = in_flight;

    // Pops while empty are silently dropped.
    assign pop = bus.val_read && !is_empty;

    // Slots already claimed: stored words plus the read still in flight.
    // Pops in this cycle are not credited back, which keeps the buffer from
    // ever overflowing while still allowing one word per cycle at steady state.
    assign credit_used = CRD_W'(count) + CRD_W'(in_flight);

    assign issue = (rd_addr < ADDR_W'(DEPTH)) && (credit_used < CRD_W'(BUF_DEPTH));

    // Prefetch engine: registered ROM read, address saturates at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr   <= '0;
            in_flight <= 1'b0;
            rom_q     <= '0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                rom_q   <= rom_word(rd_addr);
                rd_addr <= rd_addr + ADDR_W'(1);
            end
        end
    end

    // Buffer write side
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            buf_mem[wr_ptr] <= rom_q;
            wr_ptr          <= wr_ptr + PTR_W'(1);
        end
    end

    // Buffer read pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // First-word-fall-through head, forced to zero when nothing is valid.
    assign bus.out   = is_empty ? '0 : buf_mem[rd_ptr];
    assign bus.empty = is_empty;

endmodule

// File: tb/tb_sparse_fetcher.sv
// Bench for sparse_fetcher: a hand-built vector table for the reset/fill
// sequence, hand-written corner sequences, and random pop/reset traffic,
// all compared against a queue-based model of the stream.
module tb_sparse_fetcher;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned BUF_DEPTH = 4;

    logic clk;
    logic rst;

    sparse_fetcher_if #(.WIDTH(WIDTH)) bus ();

    sparse_fetcher #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: next address to fetch, word in flight (-1 if none), buffered words.
    int m_next;
    int m_pipe;
    int m_q[$];
    int deliv_next;

    typedef struct {
        logic       vr;
        logic       exp_empty;
        logic [7:0] exp_out;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next     = 0;
        m_pipe     = -1;
        m_q.delete();
        deliv_next = 1;
    endtask

    // One clock edge of the stream: pop head, land in-flight word, maybe fetch.
    task automatic model_edge(input logic v);
        bit pop_ok;
        bit fetch_ok;
        int held;
        held     = m_q.size() + ((m_pipe >= 0) ? 1 : 0);
        pop_ok   = v && (m_q.size() > 0);
        fetch_ok = (m_next < int'(DEPTH)) && (held < int'(BUF_DEPTH));
        if (pop_ok) void'(m_q.pop_front());
        if (m_pipe >= 0) m_q.push_back(m_pipe);
        m_pipe = fetch_ok ? ((m_next + 1) % 256) : -1;
        if (fetch_ok) m_next++;
    endtask

    function automatic int m_out();
        return (m_q.size() > 0) ? m_q[0] : 0;
    endfunction

    // Called at posedge+1: drive, clock, then compare after the edge.
    task automatic step(input logic v);
        bus.val_read = v;
        #2;
        if (v && (m_q.size() > 0)) begin
            chk("order", 32'(bus.out), 32'(deliv_next));
            deliv_next++;
        end
        @(posedge clk);
        model_edge(v);
        #1;
        chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
        chk("out", 32'(bus.out), 32'(m_out()));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_out", 32'(bus.out), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_empty", 32'(bus.empty), 32'd1);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        bus.val_read = 1'b0;
        model_reset();

        // Reset release, 2-edge latency, fill to 4, then a few pops.
        tbl[0] = '{1'b0, 1'b1, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 8'd1};
        tbl[2] = '{1'b0, 1'b0, 8'd1};
        tbl[3] = '{1'b0, 1'b0, 8'd1};
        tbl[4] = '{1'b0, 1'b0, 8'd1};
        tbl[5] = '{1'b0, 1'b0, 8'd1};
        tbl[6] = '{1'b1, 1'b0, 8'd2};
        tbl[7] = '{1'b1, 1'b0, 8'd3};
        tbl[8] = '{1'b1, 1'b0, 8'd4};
        tbl[9] = '{1'b0, 1'b0, 8'd4};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].vr);
            chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].exp_empty));
            chk($sformatf("tbl%0d_out", i), 32'(bus.out), 32'(tbl[i].exp_out));
        end

        // Continuous drain from release: pops while empty are ignored, then
        // 1..16 back to back, then exhausted.
        do_reset();
        repeat (24) step(1'b1);
        chk("drain_count", 32'(deliv_next), 32'(DEPTH + 1));
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_out", 32'(bus.out), 32'd0);

        // Burst / pause / resume.
        do_reset();
        repeat (2) step(1'b0);
        repeat (8) step(1'b1);
        repeat (6) begin
            step(1'b0);
            chk("pause_out", 32'(bus.out), 32'd9);
        end
        repeat (8) step(1'b1);
        chk("burst_count", 32'(deliv_next), 32'(DEPTH + 1));
        repeat (4) begin
            step(1'b1);
            chk("exhaust_empty", 32'(bus.empty), 32'd1);
            chk("exhaust_out", 32'(bus.out), 32'd0);
        end

        // Mid-stream asynchronous reset between edges.
        do_reset();
        repeat (2) step(1'b0);
        repeat (5) step(1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_empty", 32'(bus.empty), 32'd1);
        chk("async_out", 32'(bus.out), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        chk("restart_out", 32'(bus.out), 32'd1);

        // Alternating pops.
        do_reset();
        for (int i = 0; i < 44; i++) step(1'(i % 2));
        chk("alt_count", 32'(deliv_next), 32'(DEPTH + 1));

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else step(1'($urandom & 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
